div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_if.sv | 21 ++
 rtl/div_seq.sv | 124 ++++++++++++
 tb/tb_div_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Handshake bundle for div_seq: operation request, flush, stall and result signals.
interface div_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (div/mod/divu/modu), 35-cycle latency from accept to done.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor goes straight to DONE with a zero result.
module div_seq (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave io_div
);

    typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [1:0]  r_op;
    logic [31:0] r_dvd;     // raw dividend, then |a|, then quotient shifted in LSB-first
    logic [31:0] r_dvs;
    logic [32:0] r_rem;
    logic [5:0]  r_cnt;
    logic        r_q_neg;
    logic        r_r_neg;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_zero_fast;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [33:0] w_shift;
    logic [33:0] w_diff;
    logic        w_fits;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_accept = io_div.start && ((r_state == StIdle) || (r_state == StDone));

`ifdef DIV_ZERO_FAST_EN
    assign w_zero_fast = w_accept && (io_div.b == 32'd0);
`else
    assign w_zero_fast = 1'b0;
`endif

    assign w_signed = ~r_op[1];
    assign w_a_neg  = w_signed & r_dvd[31];
    assign w_b_neg  = w_signed & r_dvs[31];

    // Shift in the next dividend bit and try to subtract; no borrow means the bit is 1.
    assign w_shift = {r_rem, r_dvd[31]};
    assign w_diff  = w_shift - {2'b00, r_dvs};
    assign w_fits  = ~w_diff[33];

    assign w_quo_fix = r_q_neg ? (32'd0 - r_dvd) : r_dvd;
    assign w_rem_fix = r_r_neg ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

    always_comb begin
        w_state_next = r_state;
        if (io_div.flush) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) w_state_next = w_zero_fast ? StDone : StPrep;
                end
                StPrep: w_state_next = StIter;
                StIter: begin
                    if (r_cnt == 6'd31) w_state_next = StFix;
                end
                StFix:  w_state_next = StDone;
                StDone: begin
                    if (w_accept) w_state_next = w_zero_fast ? StDone : StPrep;
                    else          w_state_next = StIdle;
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= 2'b00;
            r_dvd    <= 32'd0;
            r_dvs    <= 32'd0;
            r_rem    <= 33'd0;
            r_cnt    <= 6'd0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_result <= 32'd0;
        end else if (!io_div.flush) begin
            if (w_accept) begin
                r_op  <= io_div.op;
                r_dvd <= io_div.a;
                r_dvs <= io_div.b;
            end
            case (r_state)
                StPrep: begin
                    r_dvd   <= w_a_neg ? (32'd0 - r_dvd) : r_dvd;
                    r_dvs   <= w_b_neg ? (32'd0 - r_dvs) : r_dvs;
                    r_q_neg <= w_a_neg ^ w_b_neg;
                    r_r_neg <= w_a_neg;
                    r_rem   <= 33'd0;
                    r_cnt   <= 6'd0;
                end
                StIter: begin
                    r_rem <= w_fits ? w_diff[32:0] : w_shift[32:0];
                    r_dvd <= {r_dvd[30:0], w_fits};
                    r_cnt <= r_cnt + 6'd1;
                end
                StFix: begin
                    r_result <= r_op[0] ? w_rem_fix : w_quo_fix;
                end
                default: ;
            endcase
            if (w_zero_fast) r_result <= 32'd0;
        end
    end

    assign io_div.busy   = (r_state == StPrep) || (r_state == StIter) || (r_state == StFix);
    assign io_div.done   = (r_state == StDone);
    assign io_div.result = r_result;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: arithmetic cases, latency, flush, reset, back-to-back.
module tb_div_seq;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ndone;

    always #5 clk = ~clk;

    div_seq_if u_if ();

    div_seq u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_div (u_if.slave)
    );

`ifdef DIV_ZERO_FAST_EN
    localparam int          ZeroLat    = 1;
    localparam logic [31:0] ZeroDivu   = 32'h0000_0000;
    localparam logic [31:0] ZeroModNeg = 32'h0000_0000;
`else
    localparam int          ZeroLat    = 35;
    localparam logic [31:0] ZeroDivu   = 32'hFFFF_FFFF;
    localparam logic [31:0] ZeroModNeg = 32'hFFFF_FFF9;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.op    = op;
        u_if.a     = a;
        u_if.b     = b;
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
    endtask

    task automatic await_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        bit busy_bad;
        lat      = 1;
        busy_bad = 1'b0;
        while (u_if.done !== 1'b1 && lat < 200) begin
            if (u_if.busy !== 1'b1) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, u_if.result, exp_res);
        check({tag, "_busy_run"}, {31'd0, busy_bad}, 32'd0);
        check({tag, "_busy_done"}, {31'd0, u_if.busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        launch(op, a, b);
        await_done(tag, exp_lat, exp_res);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, u_if.done}, 32'd0);
    endtask

    initial begin
        u_if.start = 1'b0;
        u_if.flush = 1'b0;
        u_if.op    = 2'b00;
        u_if.a     = 32'd0;
        u_if.b     = 32'd0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, u_if.busy}, 32'd0);
        check("rst_done", {31'd0, u_if.done}, 32'd0);
        check("rst_result", u_if.result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 35, 32'd14);
        run_op("modu_100_7", 2'b11, 32'd100, 32'd7, 35, 32'd2);
        run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFD);
        run_op("mod_m7_2",   2'b01, 32'hFFFF_FFF9, 32'd2, 35, 32'hFFFF_FFFF);
        run_op("div_7_m2",   2'b00, 32'd7, 32'hFFFF_FFFE, 35, 32'hFFFF_FFFD);
        run_op("mod_7_m2",   2'b01, 32'd7, 32'hFFFF_FFFE, 35, 32'd1);
        run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'h8000_0000);
        run_op("mod_ovf",    2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 35, 32'd0);
        run_op("divu_big",   2'b10, 32'hFFFF_FFFF, 32'd16, 35, 32'h0FFF_FFFF);
        run_op("divu_7_0",   2'b10, 32'd7, 32'd0, ZeroLat, ZeroDivu);
        run_op("mod_m7_0",   2'b01, 32'hFFFF_FFF9, 32'd0, ZeroLat, ZeroModNeg);

        // Back-to-back: second start issued during the first DONE cycle.
        launch(2'b10, 32'd10, 32'd3);
        await_done("b2b_first", 35, 32'd3);
        launch(2'b10, 32'd20, 32'd6);
        await_done("b2b_second", 35, 32'd3);
        @(negedge clk);
        check("b2b_pulse", {31'd0, u_if.done}, 32'd0);

        // Flush mid-operation: flush sampled 10 edges after accept, new start 2 edges later.
        launch(2'b10, 32'd9, 32'd3);
        ndone = 0;
        repeat (9) begin
            if (u_if.done) ndone++;
            @(negedge clk);
        end
        u_if.flush = 1'b1;
        @(negedge clk);
        u_if.flush = 1'b0;
        check("flush_busy", {31'd0, u_if.busy}, 32'd0);
        check("flush_done", {31'd0, u_if.done}, 32'd0);
        check("flush_hold", u_if.result, 32'd3);
        @(negedge clk);
        launch(2'b11, 32'd9, 32'd4);
        await_done("flush_mod", 35, 32'd1);
        check("flush_no_done", ndone, 32'd0);
        @(negedge clk);

        // Flush beats start on the same edge.
        u_if.op    = 2'b10;
        u_if.a     = 32'd9;
        u_if.b     = 32'd3;
        u_if.flush = 1'b1;
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.flush = 1'b0;
        u_if.start = 1'b0;
        ndone = 0;
        repeat (40) begin
            if (u_if.done || u_if.busy) ndone++;
            @(negedge clk);
        end
        check("flush_prio", ndone, 32'd0);

        // Reset in the middle of ITER discards the operation.
        launch(2'b10, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {31'd0, u_if.busy}, 32'd0);
        check("midrst_result", u_if.result, 32'd0);
        ndone = 0;
        repeat (40) begin
            if (u_if.done || u_if.busy) ndone++;
            @(negedge clk);
        end
        check("midrst_quiet", ndone, 32'd0);
        run_op("post_rst", 2'b10, 32'd100, 32'd7, 35, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
